uart_rx_monitor: RTL and testbench

Serial receive stage that consumes the UART txd line driven by chip_top and turns it into bytes for the testbench console/checker. It oversamples the line at CLK_DIV clocks per bit and decodes 8N1 frames. Decoded bytes are buffered in a small FIFO with a valid/ready output. Framing errors and FIFO overflows are flagged. Synthesizable; also reused as an on-FPGA loopback checker.

---
 rtl/uart_rx_monitor.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with oversampled decode, FWFT byte FIFO, framing/overflow
// flags and an optional post-byte idle-line pulse.
module uart_rx_monitor #(
  parameter int CLK_DIV      = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rxd,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          busy_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  input  logic                          clr_i,
  output logic                          idle_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int CW        = $clog2(CLK_DIV);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LW        = AW + 1;
  localparam int IDLE_CYC  = IDLE_TIMEOUT * CLK_DIV;
  localparam int IW        = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam int IDLE_LAST = (IDLE_CYC > 0) ? IDLE_CYC - 1 : 0;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic          sync1, rxd_s, rxd_d;
  logic [1:0]    fill;
  logic          fall;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          push, pop, full, push_ok, drop;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [LW-1:0] level, level_pop, level_next;
  logic [7:0]    head;
  logic          idle_armed;
  logic [IW-1:0] idle_cnt;

  // NOTE: every register in this file uses non-blocking assignments so all
  // flops update together and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
      fill  <= 2'd0;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
      rxd_d <= rxd_s;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  // Edges only count once rxd_d holds a real sample, so a line already low
  // when reset releases is never taken as a start bit.
  assign fall = (fill == 2'd3) && rxd_d && !rxd_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        IDLE: if (fall) begin
          state   <= START;
          cnt     <= HALF_LOAD;
          bit_cnt <= '0;
        end
        START: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rxd_s) state <= IDLE;
          else begin
            state <= DATA;
            cnt   <= BIT_LOAD;
          end
        end
        DATA: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shreg   <= {rxd_s, shreg[7:1]};
            cnt     <= BIT_LOAD;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rxd_s) state <= IDLE;
          else begin
            frame_err_o <= 1'b1;
            state       <= BREAK;
          end
        end
        BREAK: if (rxd_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign push    = (state == STOP) && (cnt == '0) && rxd_s;
  assign pop     = valid_o && ready_i;
  assign full    = (level == LW'(FIFO_DEPTH));
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  // NOTE: every signal gets a default before any condition so no latch forms.
  always_comb begin
    rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
    level_pop  = level - {{(LW-1){1'b0}}, pop};
    level_next = level_pop + {{(LW-1){1'b0}}, push_ok};
  end

  // NOTE: the storage array is deliberately not reset; pointers and level
  // alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok && !clr_i) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_o <= 1'b0;
      head       <= '0;
    end else if (clr_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      level  <= level_next;
      if (drop) overflow_o <= 1'b1;
      // Head register gives fall-through data and holds the last byte when empty.
      if (level_next != '0)
        head <= (push_ok && level_pop == '0) ? shreg : mem[rd_next];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_armed <= 1'b0;
      idle_cnt   <= '0;
      idle_o     <= 1'b0;
    end else begin
      idle_o <= 1'b0;
      if (IDLE_TIMEOUT == 0) begin
        idle_armed <= 1'b0;
      end else if (push_ok && !clr_i) begin
        idle_armed <= 1'b1;
        idle_cnt   <= '0;
      end else if (idle_armed && state == IDLE) begin
        if (fall) idle_armed <= 1'b0;
        else if (rxd_s) begin
          if (idle_cnt == IW'(IDLE_LAST)) begin
            idle_o     <= 1'b1;
            idle_armed <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign data_o  = head;
  assign valid_o = (level != '0);
  assign level_o = level;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: latency, glitch rejection, framing
// error with break, overflow, full-with-pop, mid-frame reset and idle pulse.
module tb_uart_rx_monitor;
  localparam int CLK_DIV      = 16;
  localparam int FIFO_DEPTH   = 8;
  localparam int IDLE_TIMEOUT = 2;
  localparam int LW           = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rxd = 1'b1;
  logic          ready_i = 1'b0;
  logic          clr_i = 1'b0;
  logic [7:0]    data_o;
  logic          valid_o, busy_o, frame_err_o, overflow_o, idle_o;
  logic [LW-1:0] level_o;

  int         checks = 0;
  int         failures = 0;
  int         ferr_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] popped[$];

  uart_rx_monitor #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .frame_err_o(frame_err_o),
    .overflow_o(overflow_o), .clr_i(clr_i), .idle_o(idle_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  // Observe on the falling edge: what is seen here is what the next rising edge acts on.
  always @(negedge clk) begin
    if (valid_o && ready_i) popped.push_back(data_o);
    if (frame_err_o) ferr_cnt++;
    if (busy_o) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      tick(CLK_DIV);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_o && n < 400) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, base, f0, b0;

    // Reset state
    tick(3);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_level", level_o, 0);
    check("rst_data", data_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_idle", idle_o, 0);
    rstn = 1'b1;
    tick(6);

    // Two good bytes, consumer always ready; first must appear 155 cycles after start edge
    ready_i = 1'b1;
    base = popped.size();
    f0 = ferr_cnt;
    fork
      send_frame(8'h55, 1'b1);
      wait_valid(n);
    join
    check("latency_55", n, 155);
    send_frame(8'hA3, 1'b1);
    tick(4);
    check("good_count", popped.size() - base, 2);
    check("good_byte0", popped[base], 8'h55);
    check("good_byte1", popped[base+1], 8'hA3);
    check("good_no_ferr", ferr_cnt - f0, 0);
    check("good_data_hold", data_o, 8'hA3);
    check("good_empty", valid_o, 0);

    // Short low glitch on idle line
    ready_i = 1'b0;
    b0 = busy_cnt;
    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    tick(3 * CLK_DIV);
    check("glitch_busy_seen", busy_cnt > b0, 1);
    check("glitch_busy_end", busy_o, 0);
    check("glitch_valid", valid_o, 0);
    check("glitch_level", level_o, 0);

    // Bad stop bit then long break, then a good byte
    ready_i = 1'b1;
    base = popped.size();
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    tick(40 * CLK_DIV);
    check("break_busy", busy_o, 1);
    rxd = 1'b1;
    tick(2 * CLK_DIV);
    check("break_exit", busy_o, 0);
    send_frame(8'h81, 1'b1);
    tick(4);
    check("ferr_once", ferr_cnt - f0, 1);
    check("ferr_count", popped.size() - base, 1);
    check("ferr_byte", popped[base], 8'h81);

    // Overflow: 10 bytes into an 8-deep FIFO with no consumer
    ready_i = 1'b0;
    base = popped.size();
    for (int i = 0; i < 10; i++) send_frame(8'(i), 1'b1);
    tick(4);
    check("ovf_level", level_o, 8);
    check("ovf_flag", overflow_o, 1);
    check("ovf_head", data_o, 8'h00);
    ready_i = 1'b1;
    tick(12);
    ready_i = 1'b0;
    check("ovf_drain_count", popped.size() - base, 8);
    for (int i = 0; i < 8; i++) check($sformatf("ovf_drain%0d", i), popped[base+i], i);
    check("ovf_sticky", overflow_o, 1);
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    check("clr_overflow", overflow_o, 0);
    check("clr_level", level_o, 0);

    // Full FIFO, single pop on the exact cycle of the ninth push
    base = popped.size();
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1);
    check("full_level", level_o, 8);
    fork
      send_frame(8'h08, 1'b1);
      begin
        tick(154);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
      end
    join
    tick(2);
    check("fullpop_level", level_o, 8);
    check("fullpop_no_ovf", overflow_o, 0);
    ready_i = 1'b1;
    tick(12);
    check("fullpop_count", popped.size() - base, 9);
    check("fullpop_first", popped[base], 8'h00);
    for (int i = 1; i <= 8; i++) check($sformatf("fullpop_drain%0d", i), popped[base+i], i);

    // Reset in the middle of a 0xFF frame, line held low across release
    base = popped.size();
    rxd = 1'b0;
    tick(CLK_DIV);
    rxd = 1'b1;
    tick(3 * CLK_DIV + 8);
    check("mid_frame_busy", busy_o, 1);
    rxd = 1'b0;
    rstn = 1'b0;
    tick(3);
    check("rst_mid_busy", busy_o, 0);
    rstn = 1'b1;
    tick(4 * CLK_DIV);
    check("low_line_no_start", busy_o, 0);
    rxd = 1'b1;
    tick(2 * CLK_DIV);
    m = 0;
    fork
      send_frame(8'h42, 1'b1);
      begin
        wait_valid(n);
        if (n < 400) begin
          while (!idle_o && m < 100) begin
            tick(1);
            m++;
          end
        end
      end
    join
    check("rst_latency", n, 155);
    check("idle_delay", m, 32);
    tick(1);
    check("idle_pulse_end", idle_o, 0);
    check("rst_count", popped.size() - base, 1);
    check("rst_byte", popped[base], 8'h42);
    check("rst_data_o", data_o, 8'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
